// File: rtl/hwag_crank_gen.sv
// hwag_crank_gen
// Toothed-wheel (crank) waveform generator. Produces a 60-2 style wheel
// signal with a programmable per-slot length, plus ground-truth markers
// (slot index, gap flag, tooth/revolution strobes, revolution counter)
// so a capture path can be checked against what was actually sent.
//
// Ports:
//   clk          system clock
//   rst          synchronous active-high reset (wins over ena)
//   ena          global clock enable; when low, everything holds
//   run          1 = generate; 0 = stop at the next slot boundary
//   period       slot length in clocks, sampled only at slot start
//   vr_out       generated wheel signal
//   tooth_num    current slot index 0..TEETH_TOTAL-1
//   gap_slot     current slot is a missing tooth
//   tooth_strobe first cycle of every real tooth
//   rev_strobe   first cycle of slot 0
//   rev_cnt      completed revolutions, wraps modulo 2^16
//   busy         generator is not idle
module hwag_crank_gen #(
  parameter int TEETH_TOTAL   = 60,
  parameter int TEETH_MISSING = 2,
  parameter int PERIOD_W      = 24,
  parameter int PERIOD_MIN    = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ena,
  input  logic                run,
  input  logic [PERIOD_W-1:0] period,
  output logic                vr_out,
  output logic [7:0]          tooth_num,
  output logic                gap_slot,
  output logic                tooth_strobe,
  output logic                rev_strobe,
  output logic [15:0]         rev_cnt,
  output logic                busy
);

  typedef enum logic [1:0] {IDLE, HIGH, LOW, MISS} state_t;

  localparam logic [PERIOD_W-1:0] P_MIN     = PERIOD_W'(PERIOD_MIN);
  localparam logic [7:0]          IDX_WRAP  = 8'(TEETH_TOTAL);
  localparam logic [7:0]          IDX_FIRST_GAP = 8'(TEETH_TOTAL - TEETH_MISSING);

  state_t              state_reg, state_next;
  logic [PERIOD_W-1:0] sc_reg, sc_next;
  logic [PERIOD_W-1:0] p_reg, p_next;
  logic                vr_reg, vr_next;
  logic [7:0]          tooth_reg, tooth_next;
  logic                gap_reg, gap_next;
  logic                tstb_reg, tstb_next;
  logic                rstb_reg, rstb_next;
  logic [15:0]         rev_reg, rev_next;

  logic [PERIOD_W-1:0] period_clamped;
  logic [PERIOD_W-1:0] hi, lo;
  logic [7:0]          idx_inc, idx_after;
  logic                idx_wrap;
  logic                slot_end;

  // Clamp is applied only where p is latched, so mid-slot changes of
  // period never disturb the slot in progress.
  assign period_clamped = (period < P_MIN) ? P_MIN : period;

  // Odd periods give the extra cycle to the low phase.
  assign hi = p_reg >> 1;
  assign lo = p_reg - hi;

  assign idx_inc   = tooth_reg + 8'd1;
  assign idx_wrap  = (idx_inc == IDX_WRAP);
  assign idx_after = idx_wrap ? 8'd0 : idx_inc;

  always_comb begin
    state_next = state_reg;
    sc_next    = sc_reg;
    p_next     = p_reg;
    vr_next    = vr_reg;
    tooth_next = tooth_reg;
    gap_next   = gap_reg;
    rev_next   = rev_reg;
    tstb_next  = 1'b0;
    rstb_next  = 1'b0;
    slot_end   = 1'b0;

    unique case (state_reg)
      IDLE: begin
        if (run) begin
          state_next = HIGH;
          sc_next    = '0;
          p_next     = period_clamped;
          vr_next    = 1'b1;
          tooth_next = 8'd0;
          gap_next   = 1'b0;
          tstb_next  = 1'b1;
          rstb_next  = 1'b1;
        end
      end
      HIGH: begin
        if (sc_reg == hi - 1'b1) begin
          state_next = LOW;
          sc_next    = '0;
          vr_next    = 1'b0;
        end else begin
          sc_next = sc_reg + 1'b1;
        end
      end
      LOW: begin
        if (sc_reg == lo - 1'b1) slot_end = 1'b1;
        else                     sc_next  = sc_reg + 1'b1;
      end
      MISS: begin
        if (sc_reg == p_reg - 1'b1) slot_end = 1'b1;
        else                        sc_next  = sc_reg + 1'b1;
      end
      default: state_next = IDLE;
    endcase

    if (slot_end) begin
      sc_next = '0;
      if (!run) begin
        // Stop: index and revolution count stay where they are.
        state_next = IDLE;
        vr_next    = 1'b0;
        gap_next   = 1'b0;
      end else begin
        tooth_next = idx_after;
        p_next     = period_clamped;
        if (idx_wrap) begin
          rev_next  = rev_reg + 16'd1;
          rstb_next = 1'b1;
        end
        if (idx_after >= IDX_FIRST_GAP) begin
          state_next = MISS;
          vr_next    = 1'b0;
          gap_next   = 1'b1;
        end else begin
          state_next = HIGH;
          vr_next    = 1'b1;
          gap_next   = 1'b0;
          tstb_next  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      sc_reg    <= '0;
      p_reg     <= '0;
      vr_reg    <= 1'b0;
      tooth_reg <= 8'd0;
      gap_reg   <= 1'b0;
      tstb_reg  <= 1'b0;
      rstb_reg  <= 1'b0;
      rev_reg   <= 16'd0;
    end else if (ena) begin
      state_reg <= state_next;
      sc_reg    <= sc_next;
      p_reg     <= p_next;
      vr_reg    <= vr_next;
      tooth_reg <= tooth_next;
      gap_reg   <= gap_next;
      tstb_reg  <= tstb_next;
      rstb_reg  <= rstb_next;
      rev_reg   <= rev_next;
    end
  end

  assign vr_out       = vr_reg;
  assign tooth_num    = tooth_reg;
  assign gap_slot     = gap_reg;
  assign tooth_strobe = tstb_reg;
  assign rev_strobe   = rstb_reg;
  assign rev_cnt      = rev_reg;
  assign busy         = (state_reg != IDLE);

endmodule

// File: tb/tb_hwag_crank_gen.sv
// tb_hwag_crank_gen
// Randomised bench for hwag_crank_gen. A slot-level reference model
// (every slot is p enabled cycles; a real tooth is high for the first
// p/2 of them) predicts the full output vector after each clock edge and
// pushes it into a scoreboard queue; a separate monitor pops and compares
// after every edge.
module tb_hwag_crank_gen;

  localparam int TT = 60;
  localparam int TM = 2;
  localparam int PW = 24;
  localparam int PMIN = 4;

  typedef struct packed {
    logic        vr;
    logic [7:0]  tooth;
    logic        gap;
    logic        tstb;
    logic        rstb;
    logic [15:0] rev;
    logic        busy;
  } out_t;

  logic          clk = 1'b0;
  logic          rst, ena, run;
  logic [PW-1:0] period;
  logic          vr_out, gap_slot, tooth_strobe, rev_strobe, busy;
  logic [7:0]    tooth_num;
  logic [15:0]   rev_cnt;

  always #5 clk = ~clk;

  hwag_crank_gen #(
    .TEETH_TOTAL(TT), .TEETH_MISSING(TM), .PERIOD_W(PW), .PERIOD_MIN(PMIN)
  ) dut (
    .clk(clk), .rst(rst), .ena(ena), .run(run), .period(period),
    .vr_out(vr_out), .tooth_num(tooth_num), .gap_slot(gap_slot),
    .tooth_strobe(tooth_strobe), .rev_strobe(rev_strobe),
    .rev_cnt(rev_cnt), .busy(busy)
  );

  out_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model state: slot-level view only.
  int m_active, m_idx, m_pos, m_p, m_rev;

  function automatic int clamp_p(input logic [PW-1:0] per);
    return (per < PMIN) ? PMIN : int'(per);
  endfunction

  task automatic model_step(input logic r, input logic e, input logic ru,
                            input logic [PW-1:0] per);
    out_t x;
    logic g;
    if (r) begin
      m_active = 0; m_idx = 0; m_pos = 0; m_p = 0; m_rev = 0;
    end else if (e) begin
      if (!m_active) begin
        if (ru) begin
          m_active = 1; m_idx = 0; m_pos = 0; m_p = clamp_p(per);
        end
      end else if (m_pos == m_p - 1) begin
        if (!ru) begin
          m_active = 0;
        end else begin
          m_idx = (m_idx + 1) % TT;
          if (m_idx == 0) m_rev = (m_rev + 1) % 65536;
          m_pos = 0;
          m_p = clamp_p(per);
        end
      end else begin
        m_pos++;
      end
    end
    g      = (m_active != 0) && (m_idx >= TT - TM);
    x.vr   = (m_active != 0) && !g && (m_pos < m_p / 2);
    x.tooth = 8'(m_idx);
    x.gap  = g;
    x.tstb = (m_active != 0) && !g && (m_pos == 0);
    x.rstb = (m_active != 0) && (m_idx == 0) && (m_pos == 0);
    x.rev  = 16'(m_rev);
    x.busy = (m_active != 0);
    sb_q.push_back(x);
  endtask

  // Drive one cycle's inputs at the falling edge and predict the result.
  task automatic drive(input logic r, input logic e, input logic ru,
                       input logic [PW-1:0] per);
    @(negedge clk);
    rst = r; ena = e; run = ru; period = per;
    model_step(r, e, ru, per);
  endtask

  // Monitor: one comparison of the whole output vector per clock edge.
  always @(posedge clk) begin
    out_t a, x;
    #1;
    if (sb_q.size() > 0) begin
      x = sb_q.pop_front();
      a = '{vr_out, tooth_num, gap_slot, tooth_strobe, rev_strobe, rev_cnt, busy};
      n_checks++;
      if (a !== x) begin
        n_errors++;
        $display("FAIL outputs t=%0t: got vr=%b tn=%0d gap=%b ts=%b rs=%b rev=%0d busy=%b, want vr=%b tn=%0d gap=%b ts=%b rs=%b rev=%0d busy=%b",
                 $time, a.vr, a.tooth, a.gap, a.tstb, a.rstb, a.rev, a.busy,
                 x.vr, x.tooth, x.gap, x.tstb, x.rstb, x.rev, x.busy);
      end else if (a.rstb && a.busy && ena) begin
        $display("rev start: rev_cnt=%0d t=%0t", a.rev, $time);
      end
    end
  end

  initial begin
    logic          r_run;
    logic [PW-1:0] r_per;
    rst = 1'b1; ena = 1'b0; run = 1'b0; period = '0;
    m_active = 0; m_idx = 0; m_pos = 0; m_p = 0; m_rev = 0;

    // Reset state, idle hold.
    drive(1'b1, 1'b0, 1'b0, 24'd8);
    drive(1'b1, 1'b1, 1'b1, 24'd8);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b0, 24'd8);

    // Basic revolution: period 8, just over two revolutions.
    for (int i = 0; i < 1000; i++) drive(1'b0, 1'b1, 1'b1, 24'd8);

    // Odd period and clamp.
    for (int i = 0; i < 100; i++) drive(1'b0, 1'b1, 1'b1, 24'd7);
    for (int i = 0; i < 100; i++) drive(1'b0, 1'b1, 1'b1, 24'd1);

    // Stop, hold in idle, restart at slot 0.
    for (int i = 0; i < 30; i++) drive(1'b0, 1'b1, 1'b0, 24'd8);
    for (int i = 0; i < 50; i++) drive(1'b0, 1'b1, 1'b1, 24'd12);

    // Enable stall inside a high phase region.
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 1'b1, 24'd5);
    for (int i = 0; i < 20; i++) drive(1'b0, 1'b1, 1'b1, 24'd12);

    // Random mix: period changes mid-slot, enable gaps, stops, resets.
    r_run = 1'b1;
    r_per = 24'd8;
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 49) == 0) r_per = PW'($urandom_range(0, 14));
      if ($urandom_range(0, 249) == 0) r_run = ~r_run;
      drive(($urandom_range(0, 1999) == 0), ($urandom_range(0, 9) != 0),
            r_run, r_per);
    end

    // Reset in the middle of a run, then restart immediately.
    drive(1'b1, 1'b0, 1'b1, 24'd9);
    for (int i = 0; i < 40; i++) drive(1'b0, 1'b1, 1'b1, 24'd9);

    repeat (2) @(posedge clk);
    #2;
    if (sb_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: got %0d pending, want 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/hwag_crank_gen.md
# hwag_crank_gen

Crank-wheel signal generator: the transmit-side counterpart of the HWAG capture path. It synthesises a toothed-wheel waveform (default 60-2) with a programmable tooth period. Its output drives the HWAG `cap_in` input in bench and in-system self-test, and doubles as a crank emulator for bench ignition testing. Tooth index, gap and revolution strobes are exported so checkers can correlate HWAG `tcnt`/`acnt` against ground truth.

## Interface
Parameters:
- `TEETH_TOTAL`, 60: tooth slots per revolution, including the missing ones.
- `TEETH_MISSING`, 2: missing slots at the end of the revolution.
- `PERIOD_W`, 24: width of the tooth period, matching the PCNT width.
- `PERIOD_MIN`, 4: minimum slot length in clocks; smaller requests are clamped to this value.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  reset, synchronous, active-high.
- `ena`  in  1  global clock enable; when low, all state and outputs hold.
- `run`  in  1  level; 1 starts or keeps generation, 0 stops at the next slot boundary.
- `period`  in  PERIOD_W  slot length in clocks; sampled only at slot start.
- `vr_out`  out  1  generated wheel signal (registered).
- `tooth_num`  out  8  current slot index, 0..TEETH_TOTAL-1.
- `gap_slot`  out  1  1 while the current slot is a missing tooth.
- `tooth_strobe`  out  1  one-cycle pulse on the first cycle of every real tooth.
- `rev_strobe`  out  1  one-cycle pulse on the first cycle of slot 0.
- `rev_cnt`  out  16  completed-revolution counter; wraps modulo 2^16.
- `busy`  out  1  1 in any state other than IDLE.

## Operation
- **State machine:** IDLE, HIGH, LOW, MISS. The slot counter `sc` and latched period `p` are internal registers.
- **Period latch:** `p = max(period, PERIOD_MIN)`, captured at every slot start and never mid-slot.
- **Phase split:** `hi = p >> 1`; `lo = p - hi`. Odd periods therefore give the extra cycle to the low phase.
- **IDLE → HIGH:** when `run` is 1. Sets `tooth_num = 0`, `sc = 0`, latches `p`, and pulses `tooth_strobe` and `rev_strobe`.
- **HIGH:** `vr_out = 1`. After `hi` cycles → LOW.
- **LOW:** `vr_out = 0`. After `lo` cycles the slot ends.
- **MISS:** `vr_out = 0` for `p` cycles. `gap_slot = 1`.
- **Slot end:** `tooth_num` increments.
  - If `tooth_num` reaches `TEETH_TOTAL`, it wraps to 0, `rev_cnt` increments, and `rev_strobe` fires.
  - The next state is MISS when the new index is ≥ `TEETH_TOTAL - TEETH_MISSING`, otherwise HIGH (with `tooth_strobe`).
- **Stop:** if `run` = 0 at a slot end, go to IDLE instead of starting the next slot. `vr_out = 0`, `tooth_num` is held, `rev_cnt` is held.
  - A later `run` restarts at slot 0; `rev_cnt` is not cleared.
  - Deasserting `run` never truncates a slot.
- **Reset:** `rst` (mid-operation included) forces IDLE. All outputs and internal registers go to 0 on the next edge, regardless of `ena`.
- **Enable:** with `ena = 0`, `sc`, state and all outputs freeze, so strobes hold their value. Checkers qualify strobes with `ena`.
- **Slot counter arithmetic:** `sc` is PERIOD_W bits and compares against `hi-1`, `lo-1` and `p-1`. It never overflows because `p ≤ 2^PERIOD_W - 1`.

## Timing
- **Registered outputs:** all outputs are registered with zero combinational paths from inputs.
- **Start latency:** `run` sampled high in IDLE (with `ena = 1`) at edge N gives `vr_out = 1` and both strobes high from edge N+1.
- **Real tooth:** exactly `p` enabled cycles: `hi` high, then `lo` low.
- **Gap:** low time is `lo + TEETH_MISSING*p` consecutive enabled cycles. For p = 8 that is 4 + 16 = 20.
- **Revolution:** `TEETH_TOTAL*p` enabled cycles.
- **Strobe width:** exactly one enabled cycle.
- **Rising edges:** `vr_out` rises coincide with `tooth_strobe`.
- **Period change:** a new `period` takes effect on the first slot starting after it is applied, with no glitch.

## Test plan
- **Basic revolution:** `period` = 8, `run` = 1, `ena` = 1 → 58 pulses of 4 high / 4 low, then 20 low cycles. `rev_strobe` every 480 cycles. `rev_cnt` = 1 after the first wrap. `gap_slot` high for slots 58–59.
- **Odd period and clamp:** `period` = 7 gives 3 high / 4 low. `period` = 1 is clamped to 4, giving 2 high / 2 low.
- **Mid-slot period change:** `period` changes 8→12 at cycle 2 of tooth 5 → tooth 5 stays 8 cycles, tooth 6 is 6 high / 6 low.
- **Stop and restart:** `run` drops during HIGH of tooth 10 → tooth 10 completes, then `busy` = 0, `vr_out` = 0, `tooth_num` = 10. Reasserting `run` restarts at slot 0 with `rev_strobe`.
- **Enable stall:** `ena` low for 5 cycles inside a high phase → high phase measures `hi` + 5 clocks. All outputs are unchanged during the stall.
- **Reset mid-operation:** `rst` pulsed mid-gap → next cycle all outputs are 0 and state is IDLE. With `run` = 1 after reset, `vr_out` rises 1 cycle later at slot 0.
- **Loopback:** drive HWAG `cap_in` from `vr_out` with `period` = 1000 → `hwag_start` asserts within 2 revolutions. HWAG `tcnt_out` tracks `tooth_num` at a fixed offset.
